// File: rtl/cmn_reg_arb_pkg.sv
// rtl/cmn_reg_arb_pkg.sv - shared types and helpers for the register-bank arbiter
package cmn_reg_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // 32-bit one-hot of idx; all-zero when idx falls outside [0, n)
  function automatic logic [31:0] onehot(input int idx, input int n);
    logic [31:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < 32) begin
      v = 32'd1 << idx;
    end
    return v;
  endfunction

endpackage

// File: rtl/cmn_rr_priority_sel.sv
// rtl/cmn_rr_priority_sel.sv - round-robin priority select: first request at or after ptr, with wrap
module cmn_rr_priority_sel #(
  parameter int p_n = 4,
  parameter int p_w = $clog2(p_n)
) (
  input  logic [p_n-1:0] req,
  input  logic [p_w-1:0] ptr,
  output logic [p_n-1:0] gnt,
  output logic [p_w-1:0] idx
);

  logic           found;
  int             pos;
  logic [p_w-1:0] sel;

  // Wrap is done by subtraction so non-power-of-two p_n works
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int k = 0; k < p_n; k++) begin
      pos = int'(ptr) + k;
      if (pos >= p_n) begin
        pos = pos - p_n;
      end
      sel = p_w'(pos);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/cmn_reg_bank_arbiter.sv
// rtl/cmn_reg_bank_arbiter.sv - round-robin, burst-lockable write arbiter in front of a register bank
module cmn_reg_bank_arbiter
  import cmn_reg_arb_pkg::*;
#(
  parameter int                 p_num_reqs    = 4,
  parameter int                 p_num_regs    = 8,
  parameter int                 p_nbits       = 32,
  parameter logic [p_nbits-1:0] p_reset_value = '0,
  parameter int                 p_max_burst   = 4,
  localparam int                AW            = $clog2(p_num_regs)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [p_num_reqs-1:0]           req_val,
  input  logic [p_num_reqs-1:0]           req_lock,
  input  logic [p_num_reqs*AW-1:0]        req_addr,
  input  logic [p_num_reqs*p_nbits-1:0]   req_data,
  output logic [p_num_reqs-1:0]           req_rdy,
  input  logic [AW-1:0]                   rd_addr,
  output logic [p_nbits-1:0]              rd_data,
  output logic [p_num_regs*p_nbits-1:0]   regs_q,
  output logic                            wr_err,
  output logic                            locked
);

  localparam int              PW          = $clog2(p_num_reqs);
  localparam int              CW          = $clog2(p_max_burst + 1);
  localparam logic [AW:0]     NUM_REGS_W  = (AW+1)'(p_num_regs);
  localparam logic [PW-1:0]   LAST_REQ    = PW'(p_num_reqs - 1);
  localparam logic [CW-1:0]   MAX_BURST_W = CW'(p_max_burst);
  localparam bit              LOCK_EN     = (p_max_burst > 1);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_err_q, wr_err_d;

  logic [p_num_reqs-1:0] rr_gnt;
  logic [PW-1:0]         rr_idx;
  logic                  fire;
  logic [PW-1:0]         fire_idx;
  logic [AW-1:0]         fire_addr;
  logic [p_nbits-1:0]    fire_data;
  logic                  fire_lock;
  logic                  addr_oor;

  logic [p_nbits-1:0]    bank [p_num_regs];

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == LAST_REQ) ? '0 : i + 1'b1;
  endfunction

  cmn_rr_priority_sel #(
    .p_n (p_num_reqs),
    .p_w (PW)
  ) u_rr_sel (
    .req (req_val),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // Grant never looks at addr/data; reset blanks it combinationally
  always_comb begin
    req_rdy  = '0;
    fire_idx = rr_idx;
    if (state_q == LOCKED) begin
      fire_idx = owner_q;
      req_rdy  = p_num_reqs'(onehot(int'(owner_q), p_num_reqs));
    end else begin
      req_rdy  = rr_gnt;
    end
    if (!reset) begin
      req_rdy = '0;
    end
  end

  assign fire      = |(req_val & req_rdy);
  assign fire_addr = req_addr[fire_idx*AW +: AW];
  assign fire_data = req_data[fire_idx*p_nbits +: p_nbits];
  assign fire_lock = req_lock[fire_idx];
  assign addr_oor  = ({1'b0, fire_addr} >= NUM_REGS_W);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    wr_err_d = fire && addr_oor;
    case (state_q)
      IDLE: begin
        if (fire) begin
          if (fire_lock && LOCK_EN) begin
            state_d = LOCKED;
            owner_d = fire_idx;
            cnt_d   = CW'(1);
          end else begin
            ptr_d   = next_idx(fire_idx);
          end
        end
      end
      LOCKED: begin
        if (fire && fire_lock && (cnt_q + 1'b1 < MAX_BURST_W)) begin
          cnt_d   = cnt_q + 1'b1;
        end else begin
          // Covers unlocking beat, final allowed beat, and owner dropping val
          state_d = IDLE;
          ptr_d   = next_idx(owner_q);
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
    end
  end

  for (genvar r = 0; r < p_num_regs; r++) begin : g_reg
    logic               en;
    logic [p_nbits-1:0] val_q, val_d;

    assign en = fire && (fire_addr == AW'(r));

    always_comb begin
      val_d = val_q;
      if (en) begin
        val_d = fire_data;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        val_q <= p_reset_value;
      end else begin
        val_q <= val_d;
      end
    end

    assign bank[r]                        = val_q;
    assign regs_q[r*p_nbits +: p_nbits]   = val_q;
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < NUM_REGS_W) begin
      rd_data = bank[rd_addr];
    end
  end

  assign wr_err = wr_err_q;
  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_cmn_reg_bank_arbiter.sv
// tb/tb_cmn_reg_bank_arbiter.sv - randomized scoreboard bench for cmn_reg_bank_arbiter
module tb_cmn_reg_bank_arbiter;

  localparam int            N    = 4;
  localparam int            R    = 6;
  localparam int            W    = 16;
  localparam int            MAXB = 4;
  localparam int            AW   = 3;
  localparam logic [W-1:0]  RV   = 16'h5A5A;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_val, req_lock, req_rdy;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_data;
  logic [AW-1:0]   rd_addr;
  logic [W-1:0]    rd_data;
  logic [R*W-1:0]  regs_q;
  logic            wr_err, locked;

  always #5 clk = ~clk;

  cmn_reg_bank_arbiter #(
    .p_num_reqs    (N),
    .p_num_regs    (R),
    .p_nbits       (W),
    .p_reset_value (RV),
    .p_max_burst   (MAXB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_lock (req_lock),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .regs_q   (regs_q),
    .wr_err   (wr_err),
    .locked   (locked)
  );

  typedef struct {
    int             cyc;
    logic [N-1:0]   rdy;
    logic           lck;
    logic           err;
    logic [W-1:0]   rd;
    logic [R*W-1:0] regs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  bit            t_val[N];
  bit            t_lock[N];
  logic [AW-1:0] t_addr[N];
  logic [W-1:0]  t_data[N];
  logic [AW-1:0] t_rd;

  logic [W-1:0]  m_bank[R];
  int            m_ptr, m_owner, m_cnt;
  bit            m_locked, m_err;

  task automatic chk(input string name, input int c, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
  endtask

  task automatic model_reset();
    for (int r = 0; r < R; r++) m_bank[r] = RV;
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0; m_err = 0;
  endtask

  function automatic int model_grant();
    if (m_locked) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (t_val[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [R*W-1:0] model_regs();
    logic [R*W-1:0] v;
    for (int r = 0; r < R; r++) v[r*W +: W] = m_bank[r];
    return v;
  endfunction

  task automatic model_update(input int g);
    bit f;
    f = (g >= 0) && t_val[g];
    m_err = 0;
    if (f) begin
      if (int'(t_addr[g]) < R) m_bank[t_addr[g]] = t_data[g];
      else m_err = 1;
    end
    if (!m_locked) begin
      if (f) begin
        if (t_lock[g] && MAXB > 1) begin
          m_locked = 1; m_owner = g; m_cnt = 1;
        end else begin
          m_ptr = (g + 1) % N;
        end
      end
    end else if (f && t_lock[g] && m_cnt + 1 < MAXB) begin
      m_cnt++;
    end else begin
      m_locked = 0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      t_val[i] = 0; t_lock[i] = 0; t_addr[i] = '0; t_data[i] = '0;
    end
    t_rd = '0;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_val[i]            = t_val[i];
      req_lock[i]           = t_lock[i];
      req_addr[i*AW +: AW]  = t_addr[i];
      req_data[i*W +: W]    = t_data[i];
    end
    rd_addr = t_rd;
  endtask

  task automatic reset_checks();
    chk("rst_rdy",    cyc, 128'(req_rdy), 128'(0));
    chk("rst_regs",   cyc, 128'(regs_q),  128'({R{RV}}));
    chk("rst_locked", cyc, 128'(locked),  128'(0));
    chk("rst_wr_err", cyc, 128'(wr_err),  128'(0));
  endtask

  task automatic drive_cycle(input bit rst_mid);
    exp_t e;
    int   g;
    @(negedge clk);
    cyc++;
    apply();
    g      = model_grant();
    e.cyc  = cyc;
    e.rdy  = (g >= 0) ? N'(1 << g) : '0;
    e.lck  = m_locked;
    e.err  = m_err;
    e.rd   = (int'(t_rd) < R) ? m_bank[t_rd] : '0;
    e.regs = model_regs();
    exp_q.push_back(e);
    if (rst_mid) begin
      #3;
      reset = 1'b0;
      #1;
      reset_checks();
      model_reset();
      @(posedge clk);
      #1;
      clear_stim();
      apply();
      @(negedge clk);
      reset = 1'b1;
    end else begin
      @(posedge clk);
      model_update(g);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req_rdy", e.cyc, 128'(req_rdy), 128'(e.rdy));
        chk("locked",  e.cyc, 128'(locked),  128'(e.lck));
        chk("wr_err",  e.cyc, 128'(wr_err),  128'(e.err));
        chk("rd_data", e.cyc, 128'(rd_data), 128'(e.rd));
        chk("regs_q",  e.cyc, 128'(regs_q),  128'(e.regs));
      end
    end
  end

  initial begin
    reset = 1'b0;
    clear_stim();
    apply();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    reset = 1'b1;

    // round robin across all requesters
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        t_val[i] = 1; t_lock[i] = 0; t_addr[i] = AW'(i); t_data[i] = W'(16'hA0 + i);
      end
      t_rd = AW'(c % 4);
      drive_cycle(0);
    end

    // locked burst by requester 2 with requester 0 competing
    clear_stim();
    t_val[2] = 1; t_lock[2] = 1; t_val[0] = 1;
    for (int k = 0; k < 7; k++) begin
      t_addr[2] = (k < 4) ? AW'(4 + k) : AW'(1);
      t_data[2] = W'(16'hB0 + k);
      t_addr[0] = AW'(5);
      t_data[0] = W'(16'hC0 + k);
      t_rd      = AW'(k);
      if (k == 6) begin t_val[0] = 0; t_val[2] = 0; end
      drive_cycle(0);
    end

    // early release: owner drops val after two beats
    clear_stim();
    t_val[1] = 1; t_lock[1] = 1; t_addr[1] = AW'(2); t_data[1] = 16'h1111;
    drive_cycle(0);
    drive_cycle(0);
    t_val[1] = 0; t_val[0] = 1; t_val[2] = 1; t_addr[2] = AW'(0); t_data[2] = 16'h2222;
    drive_cycle(0);
    drive_cycle(0);

    // out-of-range write, then read-during-write on addr 3
    clear_stim();
    t_val[0] = 1; t_addr[0] = AW'(7); t_data[0] = 16'hFFFF;
    drive_cycle(0);
    clear_stim();
    drive_cycle(0);
    drive_cycle(0);
    t_val[3] = 1; t_addr[3] = AW'(3); t_data[3] = 16'hDEAD; t_rd = AW'(3);
    drive_cycle(0);
    clear_stim();
    t_rd = AW'(3);
    drive_cycle(0);

    // reset during second beat of a burst, with everyone valid
    clear_stim();
    t_val[1] = 1; t_lock[1] = 1; t_addr[1] = AW'(4); t_data[1] = 16'h3333;
    drive_cycle(0);
    for (int i = 0; i < N; i++) begin
      t_val[i] = 1; t_lock[i] = 1; t_addr[i] = AW'(5); t_data[i] = W'(16'h4440 + i);
    end
    drive_cycle(1);
    for (int i = 0; i < N; i++) t_lock[i] = 0;
    drive_cycle(0);
    drive_cycle(0);

    // randomized traffic with periodic mid-cycle resets
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        t_val[i]  = ($urandom_range(0, 3) != 0);
        t_lock[i] = ($urandom_range(0, 2) == 0);
        t_addr[i] = AW'($urandom_range(0, 7));
        t_data[i] = W'($urandom);
      end
      if (m_locked && $urandom_range(0, 9) < 8) t_val[m_owner] = 1;
      t_rd = AW'($urandom_range(0, 7));
      drive_cycle(c % 500 == 499);
    end

    clear_stim();
    drive_cycle(0);
    drive_cycle(0);
    @(negedge clk);
    #5;
    chk("queue_drained", cyc, 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
